// File: rtl/router_pkg.sv
// Shared definitions for the router output-port packet reader: header layout,
// reader state encoding and the parity fold used by the accumulator.
package router_pkg;

   localparam int DATA_W      = 8;
   localparam int LEN_W       = 6;
   localparam int ADDR_W      = 2;
   localparam int CNT_W       = LEN_W + 1;
   localparam int LEN_LSB     = ADDR_W;
   localparam int LEN_MSB     = DATA_W - 1;
   localparam int TIMEOUT_DEF = 30;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HDR_WAIT = 2'd1,
      ST_BODY     = 2'd2,
      ST_PAR_WAIT = 2'd3
   } rd_state_e;

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
      return hdr[LEN_MSB:LEN_LSB];
   endfunction

   function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
      return hdr[ADDR_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] par_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/router_pkt_reader_if.sv
// FIFO-side and client-side signal bundle of one router output-port reader.
interface router_pkt_reader_if;
   import router_pkg::*;

   logic                vld_out;
   logic [DATA_W-1:0]   d_out;
   logic                ready_i;
   logic                rd_enb;
   logic [DATA_W-1:0]   pkt_data;
   logic                pkt_data_valid;
   logic [LEN_W-1:0]    pkt_len;
   logic [ADDR_W-1:0]   pkt_addr;
   logic                pkt_done;
   logic                parity_err;
   logic                timeout_err;
   logic [DATA_W-1:0]   pkt_count;

   modport master (
      input  vld_out, d_out, ready_i,
      output rd_enb, pkt_data, pkt_data_valid, pkt_len, pkt_addr,
             pkt_done, parity_err, timeout_err, pkt_count
   );

   modport slave (
      output vld_out, d_out, ready_i,
      input  rd_enb, pkt_data, pkt_data_valid, pkt_len, pkt_addr,
             pkt_done, parity_err, timeout_err, pkt_count
   );

endinterface

// File: rtl/router_parity_acc.sv
// XOR accumulator over one packet: seeded by the header, folded with each payload
// byte, and compared against the received parity byte.
module router_parity_acc
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic              match
);

   logic [DATA_W-1:0] acc_r;

   // Accumulator register; load takes priority over fold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {DATA_W{1'b0}};
      end else if (load) begin
         acc_r <= din;
      end else if (en) begin
         acc_r <= par_fold(acc_r, din);
      end else begin
         acc_r <= acc_r;
      end
   end

   assign match = (acc_r == din);

endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader: drains one router FIFO (header, payload, parity),
// re-frames payload bytes for the client and flags parity errors and stall timeouts.
module router_pkt_reader
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   router_pkt_reader_if.master bus
);

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   rd_state_e         state_r;
   rd_state_e         state_s;
   logic              rd_s;
   logic              rd_q_r;
   logic              hdr_load_s;
   logic              pay_en_s;
   logic              par_chk_s;
   logic              abort_s;
   logic              stall_s;
   logic              par_ok_s;
   logic [CNT_W-1:0]  issued_r;
   logic [CNT_W-1:0]  last_idx_s;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic [DATA_W-1:0] pkt_data_r;
   logic [DATA_W-1:0] pkt_count_r;
   logic [LEN_W-1:0]  pkt_len_r;
   logic [ADDR_W-1:0] pkt_addr_r;
   logic              data_valid_r;
   logic              done_r;
   logic              parity_err_r;
   logic              timeout_err_r;

   // Index of the parity byte among the BODY reads
   assign last_idx_s = {1'b0, pkt_len_r} + CNT_W'(1);

   // Next-state and per-cycle control decode
   always_comb begin
      state_s    = state_r;
      rd_s       = 1'b0;
      hdr_load_s = 1'b0;
      pay_en_s   = 1'b0;
      par_chk_s  = 1'b0;
      abort_s    = 1'b0;
      stall_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            rd_s = bus.vld_out & bus.ready_i;
            if (rd_s) begin
               state_s = ST_HDR_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HDR_WAIT: begin
            hdr_load_s = 1'b1;
            state_s    = ST_BODY;
         end
         ST_BODY: begin
            stall_s = bus.ready_i & ~bus.vld_out;
            if (stall_s && (tmo_cnt_r == TMO_LAST)) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
            end else begin
               pay_en_s = rd_q_r;
               rd_s     = bus.vld_out & bus.ready_i & (issued_r < last_idx_s);
               if (rd_s && ((issued_r + CNT_W'(1)) == last_idx_s)) begin
                  state_s = ST_PAR_WAIT;
               end else begin
                  state_s = ST_BODY;
               end
            end
         end
         ST_PAR_WAIT: begin
            par_chk_s = 1'b1;
            state_s   = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and "d_out valid this cycle" marker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rd_q_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         rd_q_r  <= rd_s;
      end
   end

   // Issued-read and stall counters; both only live while in BODY
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_r  <= {CNT_W{1'b0}};
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         if (state_r != ST_BODY) begin
            issued_r <= {CNT_W{1'b0}};
         end else if (rd_s) begin
            issued_r <= issued_r + CNT_W'(1);
         end else begin
            issued_r <= issued_r;
         end
         if ((state_r != ST_BODY) || rd_s || abort_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
         end else if (stall_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         end else begin
            tmo_cnt_r <= tmo_cnt_r;
         end
      end
   end

   // Header fields, held until the next header arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_len_r  <= {LEN_W{1'b0}};
         pkt_addr_r <= {ADDR_W{1'b0}};
      end else if (hdr_load_s) begin
         pkt_len_r  <= hdr_len(bus.d_out);
         pkt_addr_r <= hdr_addr(bus.d_out);
      end else begin
         pkt_len_r  <= pkt_len_r;
         pkt_addr_r <= pkt_addr_r;
      end
   end

   // Client-facing payload byte, end-of-packet strobes and good-packet count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_data_r    <= {DATA_W{1'b0}};
         data_valid_r  <= 1'b0;
         done_r        <= 1'b0;
         parity_err_r  <= 1'b0;
         timeout_err_r <= 1'b0;
         pkt_count_r   <= {DATA_W{1'b0}};
      end else begin
         if (pay_en_s) begin
            pkt_data_r <= bus.d_out;
         end else begin
            pkt_data_r <= pkt_data_r;
         end
         data_valid_r  <= pay_en_s;
         done_r        <= par_chk_s | abort_s;
         parity_err_r  <= par_chk_s & ~par_ok_s;
         timeout_err_r <= abort_s;
         if (par_chk_s && par_ok_s) begin
            pkt_count_r <= pkt_count_r + 8'd1;
         end else begin
            pkt_count_r <= pkt_count_r;
         end
      end
   end

   router_parity_acc u_parity_acc (
      .clk   (clk),
      .rst   (rst),
      .load  (hdr_load_s),
      .en    (pay_en_s),
      .din   (bus.d_out),
      .match (par_ok_s)
   );

   // Reset must silence the read strobe even though IDLE would otherwise read
   assign bus.rd_enb         = rd_s & ~rst;
   assign bus.pkt_data       = pkt_data_r;
   assign bus.pkt_data_valid = data_valid_r;
   assign bus.pkt_len        = pkt_len_r;
   assign bus.pkt_addr       = pkt_addr_r;
   assign bus.pkt_done       = done_r;
   assign bus.parity_err     = parity_err_r;
   assign bus.timeout_err    = timeout_err_r;
   assign bus.pkt_count      = pkt_count_r;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: a FIFO model feeds packets, a negedge
// monitor logs reads, payload strobes and end-of-packet events with cycle stamps.
module tb_router_pkt_reader;

   logic clk;
   logic rst;

   router_pkt_reader_if bus ();

   router_pkt_reader #(.TIMEOUT(30)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         errors    = 0;
   int         checks    = 0;
   int         cyc       = 0;
   int         exp_count = 0;
   int         rd_nready = 0;
   logic [7:0] fifo_mem [0:1023];
   logic [9:0] wr_ptr = 10'd0;
   logic [9:0] rd_ptr = 10'd0;
   logic       flush  = 1'b0;

   int         rd_cyc_q[$];
   int         dv_cyc_q[$];
   logic [7:0] dv_data_q[$];
   int         done_cyc_q[$];
   logic       done_perr_q[$];
   logic       done_terr_q[$];

   assign bus.vld_out = (rd_ptr != wr_ptr);

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: read data appears the cycle after rd_enb is sampled
   always @(posedge clk) begin
      if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (bus.rd_enb) begin
         bus.d_out <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 10'd1;
      end
   end

   // Monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.rd_enb) rd_cyc_q.push_back(cyc);
      if (bus.rd_enb && !bus.ready_i) rd_nready <= rd_nready + 1;
      if (bus.pkt_data_valid) begin
         dv_cyc_q.push_back(cyc);
         dv_data_q.push_back(bus.pkt_data);
      end
      if (bus.pkt_done) begin
         done_cyc_q.push_back(cyc);
         done_perr_q.push_back(bus.parity_err);
         done_terr_q.push_back(bus.timeout_err);
      end
   end

   function automatic logic [7:0] pay_byte(input int seed, input int i);
      logic [31:0] v;
      v = 32'(seed) * 32'd29 + 32'(i) * 32'd53 + 32'd17;
      return v[7:0] ^ {v[3:0], v[7:4]};
   endfunction

   function automatic logic [7:0] exp_parity(input logic [7:0] hdr, input int seed, input int n);
      logic [7:0] p;
      p = hdr;
      for (int i = 0; i < n; i++) p = p ^ pay_byte(seed, i);
      return p;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      fifo_mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 10'd1;
   endtask

   task automatic push_payload(input int seed, input int from, input int upto);
      for (int i = from; i < upto; i++) push_byte(pay_byte(seed, i));
   endtask

   // Bounded wait on a monitor log: 0 = reads, 1 = payload strobes, 2 = pkt_done
   task automatic wait_size(input int which, input int target, input int budget, output bit ok);
      int sz;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         case (which)
            0:       sz = rd_cyc_q.size();
            1:       sz = dv_cyc_q.size();
            default: sz = done_cyc_q.size();
         endcase
         if (sz >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.rd_enb, bus.pkt_data_valid, bus.pkt_done, bus.parity_err, bus.timeout_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b expected 00000",
                  {bus.rd_enb, bus.pkt_data_valid, bus.pkt_done, bus.parity_err, bus.timeout_err});
      end
      checks++;
      if ({bus.pkt_data, bus.pkt_len, bus.pkt_addr, bus.pkt_count} !== 24'h0) begin
         errors++;
         $display("FAIL reset_regs: got data=%0h len=%0d addr=%0d count=%0d expected all 0",
                  bus.pkt_data, bus.pkt_len, bus.pkt_addr, bus.pkt_count);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Full len-20 packet with no stalls; flip != 0 corrupts the parity byte
   task automatic test_packet(input string nm, input int seed, input logic [7:0] flip);
      int b_rd, b_dv, b_dn, t0;
      bit ok;
      b_rd = rd_cyc_q.size(); b_dv = dv_cyc_q.size(); b_dn = done_cyc_q.size();
      push_byte(8'h51);
      push_payload(seed, 0, 20);
      push_byte(exp_parity(8'h51, seed, 20) ^ flip);
      wait_size(2, b_dn + 1, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_done_wait: got no pkt_done expected one within 200 cycles", nm);
         return;
      end
      t0 = rd_cyc_q[b_rd];
      if (flip == 8'h00) exp_count++;
      checks++;
      if (dv_cyc_q.size() - b_dv !== 20) begin
         errors++;
         $display("FAIL %s_dv_count: got %0d expected 20", nm, dv_cyc_q.size() - b_dv);
      end
      for (int i = 0; i < 20 && b_dv + i < dv_cyc_q.size(); i++) begin
         checks++;
         if (dv_data_q[b_dv + i] !== pay_byte(seed, i) || dv_cyc_q[b_dv + i] !== t0 + 4 + i) begin
            errors++;
            $display("FAIL %s_dv[%0d]: got %0h@%0d expected %0h@%0d", nm, i,
                     dv_data_q[b_dv + i], dv_cyc_q[b_dv + i] - t0, pay_byte(seed, i), 4 + i);
         end
      end
      checks++;
      if (done_cyc_q[b_dn] !== t0 + 24) begin
         errors++;
         $display("FAIL %s_done_cycle: got %0d expected 24", nm, done_cyc_q[b_dn] - t0);
      end
      checks++;
      if (done_perr_q[b_dn] !== (flip != 8'h00) || done_terr_q[b_dn] !== 1'b0) begin
         errors++;
         $display("FAIL %s_flags: got perr=%b terr=%b expected perr=%b terr=0", nm,
                  done_perr_q[b_dn], done_terr_q[b_dn], (flip != 8'h00));
      end
      checks++;
      if (bus.pkt_len !== 6'd20 || bus.pkt_addr !== 2'd1 || bus.pkt_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL %s_fields: got len=%0d addr=%0d count=%0d expected 20 1 %0d", nm,
                  bus.pkt_len, bus.pkt_addr, bus.pkt_count, exp_count);
      end
   endtask

   // FIFO runs dry for 29 cycles after the 5th payload read, then refills
   task automatic test_stall29();
      int b_rd, b_dv, b_dn, t0;
      bit ok;
      b_rd = rd_cyc_q.size(); b_dv = dv_cyc_q.size(); b_dn = done_cyc_q.size();
      push_byte(8'h51);
      push_payload(3, 0, 5);
      wait_size(0, b_rd + 6, 50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall29_read_wait: got %0d reads expected 6", rd_cyc_q.size() - b_rd);
         return;
      end
      repeat (29) @(posedge clk);
      #1;
      push_payload(3, 5, 20);
      push_byte(exp_parity(8'h51, 3, 20));
      wait_size(2, b_dn + 1, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall29_done_wait: got no pkt_done expected one within 200 cycles");
         return;
      end
      t0 = rd_cyc_q[b_rd];
      exp_count++;
      // header 0, payload 2..6, dry 7..35, reads 36..51, done two after parity
      checks++;
      if (done_cyc_q[b_dn] !== t0 + 53 || done_terr_q[b_dn] !== 1'b0 || done_perr_q[b_dn] !== 1'b0) begin
         errors++;
         $display("FAIL stall29_done: got cycle=%0d terr=%b perr=%b expected 53 0 0",
                  done_cyc_q[b_dn] - t0, done_terr_q[b_dn], done_perr_q[b_dn]);
      end
      checks++;
      if (dv_cyc_q.size() - b_dv !== 20) begin
         errors++;
         $display("FAIL stall29_dv_count: got %0d expected 20", dv_cyc_q.size() - b_dv);
      end
      for (int i = 0; i < 20 && b_dv + i < dv_cyc_q.size(); i++) begin
         checks++;
         if (dv_data_q[b_dv + i] !== pay_byte(3, i)) begin
            errors++;
            $display("FAIL stall29_dv[%0d]: got %0h expected %0h", i, dv_data_q[b_dv + i], pay_byte(3, i));
         end
      end
      checks++;
      if (bus.pkt_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL stall29_count: got %0d expected %0d", bus.pkt_count, exp_count);
      end
   endtask

   // FIFO stays dry after the 5th payload read: abort, then a len-0 packet
   task automatic test_timeout_then_len0();
      int b_rd, b_dv, b_dn, r5, t0;
      bit ok;
      b_rd = rd_cyc_q.size(); b_dv = dv_cyc_q.size(); b_dn = done_cyc_q.size();
      push_byte(8'h51);
      push_payload(4, 0, 5);
      wait_size(2, b_dn + 1, 100, ok);
      checks++;
      if (!ok || rd_cyc_q.size() - b_rd < 6) begin
         errors++;
         $display("FAIL timeout_done_wait: got reads=%0d dones=%0d expected 6 1",
                  rd_cyc_q.size() - b_rd, done_cyc_q.size() - b_dn);
         return;
      end
      r5 = rd_cyc_q[b_rd + 5];
      // 30 dry cycles r5+1..r5+30; the registered pulse shows the cycle after
      checks++;
      if (done_cyc_q[b_dn] !== r5 + 31 || done_terr_q[b_dn] !== 1'b1 || done_perr_q[b_dn] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_done: got cycle=%0d terr=%b perr=%b expected 31 1 0",
                  done_cyc_q[b_dn] - r5, done_terr_q[b_dn], done_perr_q[b_dn]);
      end
      checks++;
      if (dv_cyc_q.size() - b_dv !== 5 || bus.pkt_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL timeout_side: got dv=%0d count=%0d expected 5 %0d",
                  dv_cyc_q.size() - b_dv, bus.pkt_count, exp_count);
      end
      b_rd = rd_cyc_q.size(); b_dv = dv_cyc_q.size(); b_dn = done_cyc_q.size();
      push_byte(8'h02);
      push_byte(8'h02);
      wait_size(2, b_dn + 1, 50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL len0_done_wait: got no pkt_done expected one within 50 cycles");
         return;
      end
      t0 = rd_cyc_q[b_rd];
      exp_count++;
      checks++;
      if (done_cyc_q[b_dn] !== t0 + 4 || done_perr_q[b_dn] !== 1'b0 || done_terr_q[b_dn] !== 1'b0) begin
         errors++;
         $display("FAIL len0_done: got cycle=%0d perr=%b terr=%b expected 4 0 0",
                  done_cyc_q[b_dn] - t0, done_perr_q[b_dn], done_terr_q[b_dn]);
      end
      checks++;
      if (dv_cyc_q.size() !== b_dv || bus.pkt_len !== 6'd0 || bus.pkt_addr !== 2'd2 ||
          bus.pkt_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL len0_fields: got dv=%0d len=%0d addr=%0d count=%0d expected 0 0 2 %0d",
                  dv_cyc_q.size() - b_dv, bus.pkt_len, bus.pkt_addr, bus.pkt_count, exp_count);
      end
   endtask

   // Client back-pressure for 50 cycles mid-body with bytes waiting in the FIFO
   task automatic test_ready_hold();
      int b_rd, b_dv, b_dn, b_nr;
      bit ok;
      b_rd = rd_cyc_q.size(); b_dv = dv_cyc_q.size(); b_dn = done_cyc_q.size(); b_nr = rd_nready;
      push_byte(8'h51);
      push_payload(5, 0, 20);
      push_byte(exp_parity(8'h51, 5, 20));
      wait_size(0, b_rd + 8, 50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ready_read_wait: got %0d reads expected 8", rd_cyc_q.size() - b_rd);
         return;
      end
      bus.ready_i = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (dv_cyc_q.size() - b_dv !== 7 || done_cyc_q.size() !== b_dn || rd_nready !== b_nr) begin
         errors++;
         $display("FAIL ready_hold: got dv=%0d dones=%0d reads_while_low=%0d expected 7 0 0",
                  dv_cyc_q.size() - b_dv, done_cyc_q.size() - b_dn, rd_nready - b_nr);
      end
      bus.ready_i = 1'b1;
      wait_size(2, b_dn + 1, 100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ready_done_wait: got no pkt_done expected one within 100 cycles");
         return;
      end
      exp_count++;
      checks++;
      if (done_terr_q[b_dn] !== 1'b0 || done_perr_q[b_dn] !== 1'b0 || bus.pkt_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL ready_done: got terr=%b perr=%b count=%0d expected 0 0 %0d",
                  done_terr_q[b_dn], done_perr_q[b_dn], bus.pkt_count, exp_count);
      end
      checks++;
      if (dv_cyc_q.size() - b_dv !== 20) begin
         errors++;
         $display("FAIL ready_dv_count: got %0d expected 20", dv_cyc_q.size() - b_dv);
      end
      for (int i = 0; i < 20 && b_dv + i < dv_cyc_q.size(); i++) begin
         checks++;
         if (dv_data_q[b_dv + i] !== pay_byte(5, i)) begin
            errors++;
            $display("FAIL ready_dv[%0d]: got %0h expected %0h", i, dv_data_q[b_dv + i], pay_byte(5, i));
         end
      end
   endtask

   // Reset mid-packet, drop the stale FIFO tail, then receive header 0x0D
   task automatic test_reset_mid();
      int b_rd, b_dv, b_dn, t0;
      bit ok;
      b_dv = dv_cyc_q.size();
      push_byte(8'h51);
      push_payload(6, 0, 20);
      push_byte(exp_parity(8'h51, 6, 20));
      wait_size(1, b_dv + 8, 60, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstmid_dv_wait: got %0d strobes expected 8", dv_cyc_q.size() - b_dv);
         return;
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.rd_enb, bus.pkt_data_valid, bus.pkt_done, bus.parity_err, bus.timeout_err} !== 5'b0 ||
          {bus.pkt_data, bus.pkt_len, bus.pkt_addr, bus.pkt_count} !== 24'h0) begin
         errors++;
         $display("FAIL rstmid_outputs: got rd=%b dv=%b data=%0h len=%0d count=%0d expected all 0",
                  bus.rd_enb, bus.pkt_data_valid, bus.pkt_data, bus.pkt_len, bus.pkt_count);
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_count = 0;
      b_rd = rd_cyc_q.size(); b_dv = dv_cyc_q.size(); b_dn = done_cyc_q.size();
      push_byte(8'h0D);
      push_payload(7, 0, 3);
      push_byte(exp_parity(8'h0D, 7, 3));
      wait_size(2, b_dn + 1, 50, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL post_rst_done_wait: got no pkt_done expected one within 50 cycles");
         return;
      end
      t0 = rd_cyc_q[b_rd];
      exp_count++;
      checks++;
      if (done_cyc_q[b_dn] !== t0 + 7 || done_perr_q[b_dn] !== 1'b0 || bus.pkt_len !== 6'd3 ||
          bus.pkt_addr !== 2'd1 || bus.pkt_count !== 8'(exp_count)) begin
         errors++;
         $display("FAIL post_rst_pkt: got cycle=%0d perr=%b len=%0d addr=%0d count=%0d expected 7 0 3 1 1",
                  done_cyc_q[b_dn] - t0, done_perr_q[b_dn], bus.pkt_len, bus.pkt_addr, bus.pkt_count);
      end
      checks++;
      if (dv_cyc_q.size() - b_dv !== 3) begin
         errors++;
         $display("FAIL post_rst_dv_count: got %0d expected 3", dv_cyc_q.size() - b_dv);
      end
      for (int i = 0; i < 3 && b_dv + i < dv_cyc_q.size(); i++) begin
         checks++;
         if (dv_data_q[b_dv + i] !== pay_byte(7, i)) begin
            errors++;
            $display("FAIL post_rst_dv[%0d]: got %0h expected %0h", i, dv_data_q[b_dv + i], pay_byte(7, i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_packet("normal", 1, 8'h00);
      test_packet("parity_err", 2, 8'h01);
      test_stall29();
      test_timeout_then_len0();
      test_ready_hold();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
